// File: rtl/sigma_delta_decimator.sv
// sigma_delta_decimator
//   Recovers signed PCM samples from a 1-bit delta-sigma bitstream using a
//   3rd-order CIC (sinc3) decimator with ratio R = 2**LOG2_R, followed by a
//   scale/saturate stage and a one-cycle valid strobe. The first three
//   decimation ticks after reset only fill the comb delays and do not strobe.
//
// Ports
//   clk_i        : clock, rising edge
//   rst_i        : synchronous active-high reset
//   bit_i        : bitstream sample (1 = +1, 0 = -1)
//   bit_valid_i  : qualifies bit_i; all state frozen while low
//   pcm_o        : decimated signed PCM sample, held between strobes
//   pcm_valid_o  : one-cycle pulse, pcm_o/sat_o updated this cycle
//   sat_o        : this sample was clamped to the PCM range
module sigma_delta_decimator #(
   parameter int BW     = 16,
   parameter int LOG2_R = 5
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 bit_i,
   input  logic                 bit_valid_i,
   output logic signed [BW-1:0] pcm_o,
   output logic                 pcm_valid_o,
   output logic                 sat_o
);

   // CIC register width: enough to hold R^3 gain plus sign, wraps modulo 2^W
   localparam int W  = 3 * LOG2_R + 2;
   // Extended width for the scale stage so a left shift cannot lose bits
   localparam int WX = W + BW;
   localparam int SH = 3 * LOG2_R - (BW - 1);
   localparam int unsigned SHR = (SH > 0) ? SH : 0;
   localparam int unsigned SHL = (SH < 0) ? -SH : 0;

   logic [W-1:0]      i1, i2, i3;
   logic [W-1:0]      d1, d2, d3;
   logic [LOG2_R-1:0] cnt;
   logic [1:0]        warm;

   logic [W-1:0]         x;
   logic [W-1:0]         i1_nxt, i2_nxt, i3_nxt;
   logic [W-1:0]         c1, c2, c3;
   logic signed [WX-1:0] ext;
   logic signed [WX-1:0] s;
   logic                 tick;
   logic                 clamp;
   logic signed [BW-1:0] pcm_nxt;

   always_comb begin
      x      = bit_i ? W'(1) : '1;
      // Integrators all use the old values of their predecessors
      i1_nxt = i1 + x;
      i2_nxt = i2 + i1;
      i3_nxt = i3 + i2;
      c1     = i3_nxt - d1;
      c2     = c1 - d2;
      c3     = c2 - d3;
      tick   = bit_valid_i && (&cnt);

      ext = {{(WX - W){c3[W-1]}}, c3};
      s   = (ext >>> SHR) <<< SHL;

      // Value fits in BW bits only if all bits from BW-1 upward agree
      clamp = !((&s[WX-1:BW-1]) || !(|s[WX-1:BW-1]));
      if (clamp) begin
         pcm_nxt = s[WX-1] ? {1'b1, {(BW-1){1'b0}}} : {1'b0, {(BW-1){1'b1}}};
      end else begin
         pcm_nxt = s[BW-1:0];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         i1          <= '0;
         i2          <= '0;
         i3          <= '0;
         d1          <= '0;
         d2          <= '0;
         d3          <= '0;
         cnt         <= '0;
         warm        <= '0;
         pcm_o       <= '0;
         pcm_valid_o <= 1'b0;
         sat_o       <= 1'b0;
      end else begin
         pcm_valid_o <= 1'b0;
         if (bit_valid_i) begin
            i1  <= i1_nxt;
            i2  <= i2_nxt;
            i3  <= i3_nxt;
            cnt <= cnt + LOG2_R'(1);
            if (tick) begin
               d1 <= i3_nxt;
               d2 <= c1;
               d3 <= c2;
               // Comb delays need three ticks before the output is valid
               if (warm == 2'd3) begin
                  pcm_o       <= pcm_nxt;
                  sat_o       <= clamp;
                  pcm_valid_o <= 1'b1;
               end else begin
                  warm <= warm + 2'd1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_sigma_delta_decimator.sv
module tb_sigma_delta_decimator;

   localparam int BW = 16;
   localparam int R  = 32;

   logic                 clk_i = 1'b0;
   logic                 rst_i = 1'b1;
   logic                 bit_i = 1'b0;
   logic                 bit_valid_i = 1'b0;
   logic signed [BW-1:0] pcm_o;
   logic                 pcm_valid_o;
   logic                 sat_o;

   sigma_delta_decimator #(.BW(BW), .LOG2_R(5)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .bit_i       (bit_i),
      .bit_valid_i (bit_valid_i),
      .pcm_o       (pcm_o),
      .pcm_valid_o (pcm_valid_o),
      .sat_o       (sat_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic signed [BW-1:0] pcm;
      logic                 sat;
      int                   cyc;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   acc = 0;
   int   ticks = 0;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string name, input int actual, input int expected);
      n_chk++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Monitor: every strobe must match the head of the scoreboard
   always @(negedge clk_i) begin
      if (pcm_valid_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_strobe", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("pcm", int'(pcm_o), int'(e.pcm));
            check("sat", int'(sat_o), int'(e.sat));
            check("strobe_cycle", cyc, e.cyc);
         end
      end
   end

   function automatic logic pat(input int kind, input int n);
      case (kind)
         0:       return 1'b1;
         1:       return 1'b0;
         2:       return (n % 2) == 0;
         3:       return (n % 4) != 3;
         default: return (n % 4) == 3;
      endcase
   endfunction

   task automatic do_reset();
      rst_i       = 1'b1;
      bit_i       = 1'b1;
      bit_valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      rst_i       = 1'b0;
      bit_valid_i = 1'b0;
      acc   = 0;
      ticks = 0;
      check("rst_pcm", int'(pcm_o), 0);
      check("rst_valid", int'(pcm_valid_o), 0);
      check("rst_sat", int'(sat_o), 0);
   endtask

   // Drive nbits accepted bits, with gap-1 idle cycles before each one
   task automatic run(input int kind, input int nbits, input int gap,
                      input logic signed [BW-1:0] ev, input logic es);
      for (int i = 0; i < nbits; i++) begin
         for (int g = 0; g < gap - 1; g++) begin
            bit_i       = 1'($urandom);
            bit_valid_i = 1'b0;
            @(posedge clk_i);
            #1;
         end
         bit_i       = pat(kind, acc);
         bit_valid_i = 1'b1;
         @(posedge clk_i);
         #1;
         acc++;
         if (acc % R == 0) begin
            ticks++;
            if (ticks >= 4) exp_q.push_back('{ev, es, cyc});
         end
      end
      bit_valid_i = 1'b0;
   endtask

   task automatic idle(input int n);
      bit_valid_i = 1'b0;
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   initial begin
      do_reset();
      run(0, 6 * R, 1, 16'sd32767, 1'b1);
      idle(3);
      do_reset();
      run(1, 5 * R, 1, -16'sd32768, 1'b0);
      idle(3);
      do_reset();
      run(2, 5 * R, 1, 16'sd0, 1'b0);
      idle(3);
      do_reset();
      run(3, 5 * R, 1, 16'sd16384, 1'b0);
      idle(3);
      do_reset();
      run(4, 5 * R, 1, -16'sd16384, 1'b0);
      idle(3);
      do_reset();
      run(3, 5 * R, 3, 16'sd16384, 1'b0);
      idle(3);
      // Mid-frame reset at bit 50 of the frame after the first strobe
      do_reset();
      run(0, 4 * R + 50, 1, 16'sd32767, 1'b1);
      idle(2);
      do_reset();
      run(0, 4 * R, 1, 16'sd32767, 1'b1);
      idle(R + 5);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
